// File: rtl/downscale_machine_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : downscale_machine_pkg
//  Purpose  : Shared definitions for the image down-scaling core: host mode
//             encodings, image geometry, processing FSM states and the 3x3
//             Gaussian kernel weights.
//  Revision : 1.0  initial release
// ============================================================================
package downscale_machine_pkg;

    // Host mode encodings carried on the status input
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_LOAD = 2'b10;
    localparam logic [1:0] ST_PROC = 2'b01;
    localparam logic [1:0] ST_READ = 2'b11;

    // Default image geometry
    localparam int IMG_W = 256;
    localparam int OUT_W = IMG_W / 2;
    localparam int PIX_W = 8;

    // Nine neighbours per output pixel, index 0..8 in raster order
    localparam logic [3:0] NBR_LAST  = 4'd8;
    localparam logic [3:0] NBR_DRAIN = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } proc_state_t;

    // Kernel 1 2 1 / 2 4 2 / 1 2 1, indexed by neighbour number
    function automatic logic [2:0] kernel_weight(input logic [3:0] k);
        logic [2:0] w;
        case (k)
            4'd4:                   w = 3'd4;
            4'd1, 4'd3, 4'd5, 4'd7: w = 3'd2;
            default:                w = 3'd1;
        endcase
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/downscale_machine_accum.sv
`default_nettype none
// ============================================================================
//  Module   : gauss3x3_accum
//  Purpose  : Weighted running sum of the nine neighbours of one output
//             pixel. Each valid pixel is multiplied by the kernel weight
//             selected by its neighbour index and added to the sum.
//  Ports    : clk, rst_n   clock / async active-low reset
//             i_clear      zero the sum (priority over i_valid)
//             i_valid      accumulate i_pixel this cycle
//             i_idx        neighbour index 0..8
//             i_pixel      neighbour pixel value
//             o_sum        running weighted sum
//             o_avg        o_sum >> 4 (kernel weights total 16)
//  Revision : 1.0  initial release
// ============================================================================
module gauss3x3_accum
    import downscale_machine_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int ACC_W = PIX_W + 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic [3:0]       i_idx,
    input  logic [PIX_W-1:0] i_pixel,
    output logic [ACC_W-1:0] o_sum,
    output logic [PIX_W-1:0] o_avg
);

    logic [ACC_W-1:0] r_sum;
    logic [ACC_W-1:0] w_term;

    // Max sum is 16 * (2^PIX_W - 1), so ACC_W = PIX_W + 4 never overflows
    assign w_term = ACC_W'(i_pixel) * ACC_W'(kernel_weight(i_idx));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (i_clear) begin
            r_sum <= '0;
        end else if (i_valid) begin
            r_sum <= r_sum + w_term;
        end
    end

    assign o_sum = r_sum;
    assign o_avg = r_sum[ACC_W-1:4];

endmodule
`default_nettype wire

// File: rtl/downscale_machine.sv
`default_nettype none
// ============================================================================
//  Module   : downscale_machine
//  Purpose  : Image down-sampling core. Loads an IMG_W x IMG_W grayscale
//             image, applies a 3x3 Gaussian at every even (row, col) to
//             produce an IMG_W/2 square result, and returns it on request.
//  Ports    : clk          rising-edge clock
//             rst_n        asynchronous active-low reset
//             status       00 idle, 10 load, 01 process, 11 read
//             data         pixel written in load mode
//             addr         load: row*IMG_W+col; read: row*IMG_W/2+col
//             end_process  result image complete
//             out          read-mode pixel (1-cycle latency, holds otherwise)
//  Revision : 1.0  initial release
// ============================================================================
module downscale_machine #(
    parameter int IMG_W = 256,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       status,
    input  logic [PIX_W-1:0] data,
    input  logic [15:0]      addr,
    output logic             end_process,
    output logic [PIX_W-1:0] out
);
    import downscale_machine_pkg::*;

    localparam int CW    = $clog2(IMG_W);   // input coordinate width
    localparam int OCW   = CW - 1;          // output coordinate width
    localparam int AW    = 2 * CW;          // input memory address width
    localparam int OAW   = 2 * OCW;         // output memory address width
    localparam int ACC_W = PIX_W + 4;

    proc_state_t r_state;
    proc_state_t w_next;

    logic [OCW-1:0]   r_i;
    logic [OCW-1:0]   r_j;
    logic [3:0]       r_k;
    logic             w_last;

    logic [1:0]       w_dr_sel;
    logic [1:0]       w_dc_sel;
    logic [CW-1:0]    w_row;
    logic [CW-1:0]    w_col;
    logic [AW-1:0]    w_rd_addr;

    logic [PIX_W-1:0] r_rd_data;
    logic             r_acc_valid;
    logic [3:0]       r_acc_idx;
    logic             w_acc_clear;
    logic [ACC_W-1:0] w_sum;
    logic [PIX_W-1:0] w_avg;

    logic             r_end;
    logic [PIX_W-1:0] r_out;

    logic [PIX_W-1:0] r_in_mem  [IMG_W*IMG_W];
    logic [PIX_W-1:0] r_out_mem [(IMG_W/2)*(IMG_W/2)];

    // The weighted sum itself is only observed through its >>4 view; the
    // upper address bits are don't-care for images smaller than 256x256.
    logic w_unused;
    assign w_unused = ^{w_sum, addr};

    // Neighbour coordinate with edge replication; only centre-1 can fall
    // outside the image because centres are even and at most IMG_W-2.
    function automatic logic [CW-1:0] nbr_coord(input logic [CW-1:0] centre,
                                                input logic [1:0]    sel);
        logic [CW-1:0] c;
        case (sel)
            2'd0:    c = (centre == '0) ? centre : centre - 1'b1;
            2'd1:    c = centre;
            default: c = centre + 1'b1;
        endcase
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Processing FSM
    // ------------------------------------------------------------------
    assign w_last = (&r_i) && (&r_j);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (status == ST_PROC) w_next = S_FETCH;
            end
            S_FETCH: begin
                if (status != ST_PROC)       w_next = S_IDLE;
                else if (r_k == NBR_DRAIN)   w_next = S_WRITE;
            end
            S_WRITE: begin
                if (status != ST_PROC)       w_next = S_IDLE;
                else if (w_last)             w_next = S_DONE;
                else                         w_next = S_FETCH;
            end
            S_DONE: begin
                if (status != ST_PROC)       w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output-pixel raster counters and neighbour counter. r_k runs 0..9:
    // addresses for neighbours 0..8 are issued on k=0..8 and, because the
    // input memory read is registered, the last pixel is summed on k=9.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_i <= '0;
                    r_j <= '0;
                    r_k <= '0;
                end
                S_FETCH: begin
                    if (r_k != NBR_DRAIN) r_k <= r_k + 4'd1;
                end
                S_WRITE: begin
                    r_k <= '0;
                    r_j <= r_j + 1'b1;
                    if (&r_j) r_i <= r_i + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Neighbour address generation and input memory
    // ------------------------------------------------------------------
    always_comb begin
        w_dr_sel = 2'd2;
        w_dc_sel = 2'd2;
        case (r_k)
            4'd0, 4'd1, 4'd2: w_dr_sel = 2'd0;
            4'd3, 4'd4, 4'd5: w_dr_sel = 2'd1;
            default:          w_dr_sel = 2'd2;
        endcase
        case (r_k)
            4'd0, 4'd3, 4'd6: w_dc_sel = 2'd0;
            4'd1, 4'd4, 4'd7: w_dc_sel = 2'd1;
            default:          w_dc_sel = 2'd2;
        endcase
    end

    assign w_row     = nbr_coord({r_i, 1'b0}, w_dr_sel);
    assign w_col     = nbr_coord({r_j, 1'b0}, w_dc_sel);
    assign w_rd_addr = {w_row, w_col};

    always_ff @(posedge clk) begin
        if (status == ST_LOAD) begin
            r_in_mem[addr[AW-1:0]] <= data;
        end
        r_rd_data <= r_in_mem[w_rd_addr];
    end

    // Tag each read with its neighbour index so the sum lines up one
    // cycle later with the registered memory data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_valid <= 1'b0;
            r_acc_idx   <= '0;
        end else begin
            r_acc_valid <= (r_state == S_FETCH) && (r_k <= NBR_LAST);
            r_acc_idx   <= r_k;
        end
    end

    // Sum is zeroed outside FETCH, so each pixel starts from a clean slate
    // and WRITE still sees the finished sum before it clears.
    assign w_acc_clear = (r_state != S_FETCH);

    gauss3x3_accum #(
        .PIX_W (PIX_W),
        .ACC_W (ACC_W)
    ) u_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_acc_clear),
        .i_valid (r_acc_valid),
        .i_idx   (r_acc_idx),
        .i_pixel (r_rd_data),
        .o_sum   (w_sum),
        .o_avg   (w_avg)
    );

    // ------------------------------------------------------------------
    // Output memory, read port and completion flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if ((r_state == S_WRITE) && (status == ST_PROC)) begin
            r_out_mem[{r_i, r_j}] <= w_avg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else if (status == ST_READ) begin
            r_out <= r_out_mem[addr[OAW-1:0]];
        end
    end

    // Cleared by a new load or a new start; set as the final pixel is
    // written. Survives DONE->IDLE so the host can read with it high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_end <= 1'b0;
        end else if (status == ST_LOAD) begin
            r_end <= 1'b0;
        end else if ((r_state == S_IDLE) && (status == ST_PROC)) begin
            r_end <= 1'b0;
        end else if ((r_state == S_WRITE) && (status == ST_PROC) && w_last) begin
            r_end <= 1'b1;
        end
    end

    assign end_process = r_end;
    assign out         = r_out;

endmodule
`default_nettype wire

// File: tb/tb_downscale_machine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_downscale_machine
//  Purpose  : Directed self-checking bench for downscale_machine, built with
//             a 16x16 image so complete load/process/read passes stay short.
//  Revision : 1.0  initial release
// ============================================================================
module tb_downscale_machine;
    import downscale_machine_pkg::*;

    localparam int W  = 16;
    localparam int OW = W / 2;

    localparam int IMG_UNIFORM  = 0;
    localparam int IMG_IMPULSE  = 1;
    localparam int IMG_CORNER   = 2;
    localparam int IMG_GRADIENT = 3;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [1:0]  status = ST_IDLE;
    logic [7:0]  data   = '0;
    logic [15:0] addr   = '0;
    logic        end_process;
    logic [7:0]  out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    downscale_machine #(
        .IMG_W (W),
        .PIX_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .status      (status),
        .data        (data),
        .addr        (addr),
        .end_process (end_process),
        .out         (out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pix(input int img, input int r, input int c);
        case (img)
            IMG_UNIFORM: return 100;
            IMG_IMPULSE: return (r == 2 && c == 2) ? 160 : 0;
            IMG_CORNER:  return (r == 0 && c == 0) ? 16 : 0;
            default:     return c;
        endcase
    endfunction

    // Hand-derived filter results for each test image
    function automatic int expv(input int img, input int i, input int j);
        case (img)
            IMG_UNIFORM: return 100;
            IMG_IMPULSE: return (i == 1 && j == 1) ? 40 : 0;
            IMG_CORNER:  return (i == 0 && j == 0) ? 9 : 0;
            default:     return (j == 0) ? 0 : 2 * j;
        endcase
    endfunction

    task automatic load_image(input int img);
        for (int r = 0; r < W; r++) begin
            for (int c = 0; c < W; c++) begin
                status = ST_LOAD;
                addr   = 16'(r * W + c);
                data   = 8'(pix(img, r, c));
                step();
            end
        end
        status = ST_IDLE;
        chk("end_after_load", end_process, 1'b0);
    endtask

    task automatic run_process(input bit hold);
        status = ST_PROC;
        step();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (end_process) break;
            step();
        end
        chk("proc_done", end_process, 1'b1);
        if (hold) begin
            repeat (20) step();
            chk("hold_no_restart", end_process, 1'b1);
        end
        status = ST_IDLE;
        step();
        chk("done_in_idle", end_process, 1'b1);
    endtask

    task automatic read_all(input int img, input string tag);
        for (int idx = 0; idx < OW * OW; idx++) begin
            status = ST_READ;
            addr   = 16'(idx);
            step();
            chk(tag, out, 32'(expv(img, idx / OW, idx % OW)));
        end
        status = ST_IDLE;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", out, 8'd0);
        chk("reset_end", end_process, 1'b0);
        rst_n = 1'b1;
        step();

        // Uniform image, also checks no restart while status stays 01
        load_image(IMG_UNIFORM);
        run_process(1'b1);
        read_all(IMG_UNIFORM, "uniform");

        // Impulse image and read latency / hold
        load_image(IMG_IMPULSE);
        run_process(1'b0);
        read_all(IMG_IMPULSE, "impulse");
        status = ST_READ;
        addr   = 16'd0;
        step();
        chk("lat_prev", out, 8'd0);
        addr = 16'd9;
        #1;
        chk("lat_pre_edge", out, 8'd0);
        step();
        chk("lat_one_edge", out, 8'd40);
        status = ST_IDLE;
        addr   = 16'd0;
        repeat (3) step();
        chk("hold_idle", out, 8'd40);

        // Corner clamp
        load_image(IMG_CORNER);
        run_process(1'b0);
        read_all(IMG_CORNER, "corner");

        // Horizontal gradient
        load_image(IMG_GRADIENT);
        run_process(1'b0);
        read_all(IMG_GRADIENT, "gradient");

        // Reset mid-process: out was last 14, must drop to zero immediately
        load_image(IMG_UNIFORM);
        status = ST_PROC;
        repeat (100) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_end", end_process, 1'b0);
        chk("midrst_out", out, 8'd0);
        status = ST_IDLE;
        step();
        rst_n = 1'b1;
        step();

        // Abort by mode change, then a full rerun
        status = ST_PROC;
        repeat (50) step();
        status = ST_IDLE;
        step();
        chk("abort_end", end_process, 1'b0);
        repeat (5) step();
        chk("abort_stay", end_process, 1'b0);
        run_process(1'b0);
        read_all(IMG_UNIFORM, "rerun");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/downscale_machine.md
Name: downscale_machine

Overview:
- Image down-sampling processor with three externally commanded modes.
- Load mode: loads a 256x256 8-bit grayscale image, one pixel per clock.
- Process mode: applies a 3x3 Gaussian low-pass filter at every even (row, col) position, producing a 128x128 image.
- Read mode: returns the result pixel by pixel.
- Used as the standalone compute core of the image down-sampling processor and driven by a host or sequencer.

Parameters:
- IMG_W, 256: input image width and height in pixels (square image, power of 2).
- PIX_W, 8: pixel width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- status  input  2  mode: 00 idle, 10 load, 01 process, 11 read.
- data  input  8  pixel to write in load mode.
- addr  input  16  load: input pixel index, row*256+col; read: output index, row*128+col, bits [13:0] used, [15:14] ignored.
- end_process  output  1  high when the filtered/down-sampled image is complete.
- out  output  8  read-mode pixel.

Behaviour:
- Storage:
  - in_mem: 65536 x 8, written only in load mode.
  - out_mem: 16384 x 8, written only by the processing FSM.
- Reset (rst_n=0, asynchronous):
  - out=0, end_process=0, FSM to IDLE.
  - Memory contents are not cleared.
- Load (status=10): on each rising edge, in_mem[addr]=data. Repeated writes to an address are last-write-wins.
- Read (status=11):
  - On each rising edge, out <= out_mem[addr[13:0]]. Latency is 1 cycle.
  - out holds its last value in every other mode.
- Idle (status=00): no memory writes; outputs hold.
- Processing FSM states: IDLE, FETCH, WRITE, DONE.
- Start: IDLE->FETCH on a clock where status=01 and FSM is IDLE. end_process cleared at start.
- FETCH: for output pixel (i,j) with centre (r,c)=(2i,2j):
  - Read the 9 neighbours (r+dr, c+dc), dr,dc in {-1,0,1}, one per cycle.
  - Out-of-range coordinates are clamped to 0..IMG_W-1 (edge replicate; only the -1 side can occur).
  - Accumulate in a 12-bit sum with weights 1 2 1 / 2 4 2 / 1 2 1.
- WRITE:
  - out_mem[i*128+j] = sum>>4 (truncation; max 4080>>4=255, no saturation needed).
  - Advance j, then i, in raster order.
  - After (127,127), go to DONE; otherwise return to FETCH with the accumulator cleared.
- Per-pixel cost is at most 12 cycles; the total must finish within 16384*12 cycles.
- DONE:
  - end_process=1, held until a load command (status=10) or reset.
  - No restart while status stays 01.
  - DONE->IDLE when status != 01.
  - end_process stays high in read and idle modes.
- A new start requires status=01 with the FSM in IDLE.
- status changed away from 01 mid-processing: processing aborts to IDLE, end_process=0, out_mem is partially updated.
- Load writes while processing are not permitted. Because the mode change aborts processing, they cannot corrupt a run in progress.
- Reset mid-process: immediate abort; end_process=0.

Decomposition:
- Shared package holds:
  - mode constants ST_IDLE=2'b00, ST_LOAD=2'b10, ST_PROC=2'b01, ST_READ=2'b11.
  - IMG_W and OUT_W=IMG_W/2.
  - The FSM state enum.
  - Kernel weights.
- One natural sub-module: gauss3x3_accum. It takes the neighbour index 0..8 and the pixel, and outputs the weighted running sum, clear, and sum>>4.
- Memories are inferred inline.

Test Plan:
- Uniform image, all pixels 100: load 65536 pixels, process, wait for end_process, read all 16384 outputs -> every out = 100.
- Impulse, pixel (2,2)=160 and all others 0 -> out[129]=40; all other outputs 0.
- Corner clamp, pixel (0,0)=16 and all others 0 -> out[0]=9; all others 0.
- Horizontal gradient, pixel(r,c)=c -> out(i,0)=0 and out(i,j)=2j for j>=1, e.g. out[5]=10, out[127]=254.
- Read latency: status=11, addr=129 applied before an edge (impulse image) -> out=40 after exactly one rising edge; out holds when status=00.
- Abort and reset:
  - Reset asserted mid-process -> end_process=0 immediately.
  - status=01 again -> full rerun; end_process rises; the uniform-image check passes.
  - status held at 01 after done -> no restart; end_process stays 1.
